// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 8-entry melody on a buzzer pin.
// Each ROM entry selects a tone divisor and a duration in ticks. A silent gap follows every note.
// Start, stop and loop control are handled by a small FSM.
module melody_sequencer #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned DIV_SHIFT = 0
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic       tone_out,
  output logic       busy,
  output logic       done,
  output logic [2:0] note_idx,
  output logic [2:0] note_code
);

  localparam int unsigned TICK_W  = 20;
  localparam int unsigned NTICK_W = 16;
  localparam int unsigned DUR_W   = 6;
  localparam int unsigned DIV_W   = 28;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CODE_W  = 3;
  localparam int unsigned ROM_W   = CODE_W + DUR_W;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [NTICK_W-1:0] GAP_LAST  = NTICK_W'(GAP_TICKS - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(7);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Melody ROM: {note code, duration in ticks}; a zero duration marks the end.
  function automatic logic [ROM_W-1:0] rom_entry(input logic [IDX_W-1:0] idx);
    logic [ROM_W-1:0] e;
    case (idx)
      3'd0:    e = {3'd1, 6'd4};
      3'd1:    e = {3'd3, 6'd4};
      3'd2:    e = {3'd5, 6'd4};
      3'd3:    e = {3'd0, 6'd2};
      3'd4:    e = {3'd5, 6'd2};
      3'd5:    e = {3'd6, 6'd2};
      3'd6:    e = {3'd5, 6'd8};
      default: e = {3'd0, 6'd0};
    endcase
    return e;
  endfunction

  // Full-period tone divisor for each note code (C4..B4 at 50 MHz); code 0 is a rest.
  function automatic logic [DIV_W-1:0] full_divisor(input logic [CODE_W-1:0] code);
    logic [DIV_W-1:0] d;
    case (code)
      3'd1:    d = 28'd191113;
      3'd2:    d = 28'd170265;
      3'd3:    d = 28'd151685;
      3'd4:    d = 28'd143172;
      3'd5:    d = 28'd127551;
      3'd6:    d = 28'd113636;
      3'd7:    d = 28'd101239;
      default: d = '0;
    endcase
    return d;
  endfunction

  state_t state_q, state_d;

  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [NTICK_W-1:0] ntick_q, ntick_d;
  logic [DIV_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic [IDX_W-1:0]   idx_d;
  logic [CODE_W-1:0]  code_d;
  logic               tone_d;
  logic               busy_d;
  logic               done_d;

  logic [IDX_W-1:0]   load_idx;
  logic [ROM_W-1:0]   rom_e;
  logic [DIV_W-1:0]   ds;
  logic [DIV_W-1:0]   ds_half;
  logic [DIV_W-1:0]   ds_last;
  logic [NTICK_W-1:0] dur_last;
  logic               tick_end;
  logic               play_end;
  logic               gap_end;

  // Shared decode: next ROM entry, scaled divisor and end-of-interval flags.
  always_comb begin
    load_idx = (state_q == S_GAP) ? note_idx + IDX_W'(1) : '0;
    rom_e    = rom_entry(load_idx);
    ds       = full_divisor(note_code) >> DIV_SHIFT;
    ds_half  = ds >> 1;
    ds_last  = ds - DIV_W'(1);
    dur_last = NTICK_W'(dur_q) - NTICK_W'(1);
    tick_end = (tick_q == TICK_LAST);
    play_end = tick_end && (ntick_q == dur_last);
    gap_end  = tick_end && (ntick_q == GAP_LAST);
  end

  // State register.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; stop overrides everything, including start.
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = S_LOAD;
        S_LOAD: state_d = (dur_q == '0) ? S_DONE : S_PLAY;
        S_PLAY: if (play_end) state_d = S_GAP;
        S_GAP:  if (gap_end) state_d = (note_idx == LAST_IDX) ? S_DONE : S_LOAD;
        S_DONE: state_d = loop_en ? S_LOAD : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Next values of outputs and counters, all derived from the upcoming state.
  always_comb begin
    idx_d      = note_idx;
    code_d     = note_code;
    dur_d      = dur_q;
    tick_d     = '0;
    ntick_d    = '0;
    tone_cnt_d = '0;
    tone_d     = 1'b0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_DONE) && !stop;

    if (state_d == S_IDLE) begin
      idx_d  = '0;
      code_d = '0;
      dur_d  = '0;
    end else if (state_d == S_LOAD) begin
      idx_d  = load_idx;
      code_d = rom_e[ROM_W-1:DUR_W];
      dur_d  = rom_e[DUR_W-1:0];
    end

    // Tick counters restart on every state entry and run while the state holds.
    if ((state_d == S_PLAY || state_d == S_GAP) && (state_d == state_q)) begin
      tick_d  = tick_end ? '0 : tick_q + TICK_W'(1);
      ntick_d = tick_end ? ntick_q + NTICK_W'(1) : ntick_q;
    end

    // Tone divider: count 0..Ds-1, output high for the first Ds/2 counts.
    if (state_d == S_PLAY) begin
      if (state_q == S_PLAY) begin
        tone_cnt_d = (tone_cnt_q == ds_last) ? '0 : tone_cnt_q + DIV_W'(1);
      end
      tone_d = (note_code != '0) && (tone_cnt_d < ds_half);
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      tick_q     <= '0;
      ntick_q    <= '0;
      tone_cnt_q <= '0;
      dur_q      <= '0;
      note_idx   <= '0;
      note_code  <= '0;
      tone_out   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      tick_q     <= tick_d;
      ntick_q    <= ntick_d;
      tone_cnt_q <= tone_cnt_d;
      dur_q      <= dur_d;
      note_idx   <= idx_d;
      note_code  <= code_d;
      tone_out   <= tone_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
